// File: rtl/fifo_buffer_pkg.sv
// Shared project defaults for FIFO sizing plus the request-decode helper
// used by the FIFO control logic.
package fifo_buffer_pkg;

  localparam int unsigned DEF_NB_FIFO_DATA = 8;
  localparam int unsigned DEF_NB_FIFO_ADDR = 4;

  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'b00,
    FIFO_OP_PUSH = 2'b01,
    FIFO_OP_POP  = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

  // Folds the already-qualified push/pop permissions into a single operation code.
  function automatic fifo_op_e fifo_decode_op(input logic i_push, input logic i_pop);
    fifo_op_e v_op;
    case ({i_pop, i_push})
      2'b00:   v_op = FIFO_OP_IDLE;
      2'b01:   v_op = FIFO_OP_PUSH;
      2'b10:   v_op = FIFO_OP_POP;
      2'b11:   v_op = FIFO_OP_BOTH;
      default: v_op = FIFO_OP_IDLE;
    endcase
    return v_op;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_regfile
  import fifo_buffer_pkg::*;
#(
  parameter int unsigned NB_DATA = DEF_NB_FIFO_DATA,
  parameter int unsigned NB_ADDR = DEF_NB_FIFO_ADDR
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_buffer.sv
// First-word-fall-through FIFO: pointer, occupancy and sticky error-flag
// control around a fifo_regfile storage array.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int unsigned NB_FIFO_DATA = DEF_NB_FIFO_DATA,
  parameter int unsigned NB_FIFO_ADDR = DEF_NB_FIFO_ADDR
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_fifo_WR,
  input  logic [NB_FIFO_DATA-1:0] i_fifo_WRDATA,
  input  logic                    i_fifo_RD,
  output logic [NB_FIFO_DATA-1:0] o_fifo_RDDATA,
  output logic                    o_fifo_EMPTY,
  output logic                    o_fifo_FULL,
  output logic [NB_FIFO_ADDR:0]   o_fifo_COUNT,
  output logic                    o_fifo_OVERFLOW,
  output logic                    o_fifo_UNDERFLOW
);

  localparam logic [NB_FIFO_ADDR-1:0] PTR_ONE   = {{(NB_FIFO_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_FIFO_ADDR:0]   CNT_ONE   = {{NB_FIFO_ADDR{1'b0}}, 1'b1};
  localparam logic [NB_FIFO_ADDR:0]   CNT_ZERO  = {(NB_FIFO_ADDR+1){1'b0}};
  localparam logic [NB_FIFO_ADDR:0]   CNT_DEPTH = {1'b1, {NB_FIFO_ADDR{1'b0}}};

  logic [NB_FIFO_ADDR-1:0] r_wptr;
  logic [NB_FIFO_ADDR-1:0] r_rptr;
  logic [NB_FIFO_ADDR:0]   r_count;
  logic                    r_empty;
  logic                    r_full;
  logic                    r_overflow;
  logic                    r_underflow;

  logic                    w_push;
  logic                    w_pop;
  fifo_op_e                w_op;
  logic [NB_FIFO_ADDR-1:0] w_wptr_nxt;
  logic [NB_FIFO_ADDR-1:0] w_rptr_nxt;
  logic [NB_FIFO_ADDR:0]   w_count_nxt;
  logic                    w_overflow_nxt;
  logic                    w_underflow_nxt;

  // A pop frees a slot in the same edge, so a write while full is legal when paired with a read.
  assign w_push = i_fifo_WR & (~r_full | i_fifo_RD);
  assign w_pop  = i_fifo_RD & ~r_empty;
  assign w_op   = fifo_decode_op(w_push, w_pop);

  // Next pointer, occupancy and sticky flag values
  always_comb begin
    w_wptr_nxt      = r_wptr;
    w_rptr_nxt      = r_rptr;
    w_count_nxt     = r_count;
    w_overflow_nxt  = r_overflow | (i_fifo_WR & r_full & ~i_fifo_RD);
    w_underflow_nxt = r_underflow | (i_fifo_RD & r_empty);
    case (w_op)
      FIFO_OP_PUSH: begin
        w_wptr_nxt  = r_wptr + PTR_ONE;
        w_count_nxt = r_count + CNT_ONE;
      end
      FIFO_OP_POP: begin
        w_rptr_nxt  = r_rptr + PTR_ONE;
        w_count_nxt = r_count - CNT_ONE;
      end
      FIFO_OP_BOTH: begin
        w_wptr_nxt  = r_wptr + PTR_ONE;
        w_rptr_nxt  = r_rptr + PTR_ONE;
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wptr      <= {NB_FIFO_ADDR{1'b0}};
      r_rptr      <= {NB_FIFO_ADDR{1'b0}};
      r_count     <= CNT_ZERO;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_empty     <= (w_count_nxt == CNT_ZERO);
      r_full      <= (w_count_nxt == CNT_DEPTH);
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  // Writes during reset are gated so a discarded request cannot touch storage.
  fifo_regfile #(
    .NB_DATA (NB_FIFO_DATA),
    .NB_ADDR (NB_FIFO_ADDR)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_we    (w_push & i_reset),
    .i_waddr (r_wptr),
    .i_wdata (i_fifo_WRDATA),
    .i_raddr (r_rptr),
    .o_rdata (o_fifo_RDDATA)
  );

  assign o_fifo_EMPTY     = r_empty;
  assign o_fifo_FULL      = r_full;
  assign o_fifo_COUNT     = r_count;
  assign o_fifo_OVERFLOW  = r_overflow;
  assign o_fifo_UNDERFLOW = r_underflow;

endmodule

// File: tb/tb_fifo_buffer.sv
// Scoreboard bench for fifo_buffer: directed stimulus queues expected pop data,
// a negedge monitor compares every accepted read; flags/count checked directly.
module tb_fifo_buffer;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic [7:0] wrdata;
  logic       rd;
  logic [7:0] rddata;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       ovf;
  logic       unf;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb_q [$];

  fifo_buffer dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_fifo_WR        (wr),
    .i_fifo_WRDATA    (wrdata),
    .i_fifo_RD        (rd),
    .o_fifo_RDDATA    (rddata),
    .o_fifo_EMPTY     (empty),
    .o_fifo_FULL      (full),
    .o_fifo_COUNT     (count),
    .o_fifo_OVERFLOW  (ovf),
    .o_fifo_UNDERFLOW (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read presented while not empty pops the head word shown on RDDATA.
  always @(negedge clk) begin
    if (rst_n && rd && !empty) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", rddata, $time);
      end else begin
        chk("pop_data", {24'h0, rddata}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic op(input logic w, input logic [7:0] d, input logic r, input bit acc);
    wr = w;
    wrdata = d;
    rd = r;
    if (acc) sb_q.push_back(d);
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic do_reset(input logic w, input logic [7:0] d);
    rst_n = 1'b0;
    wr = w;
    wrdata = d;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr = 1'b0;
    sb_q.delete();
  endtask

  task automatic chk_state(input string tag, input logic [4:0] c, input logic e,
                           input logic f, input logic o, input logic u);
    chk({tag, "_count"}, {27'h0, count}, {27'h0, c});
    chk({tag, "_empty"}, {31'h0, empty}, {31'h0, e});
    chk({tag, "_full"},  {31'h0, full},  {31'h0, f});
    chk({tag, "_ovf"},   {31'h0, ovf},   {31'h0, o});
    chk({tag, "_unf"},   {31'h0, unf},   {31'h0, u});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    wrdata = 8'h00;
    #1;
    do_reset(1'b0, 8'h00);
    chk_state("reset", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic FWFT write/read
    op(1'b1, 8'h11, 1'b0, 1'b1);
    op(1'b1, 8'h22, 1'b0, 1'b1);
    op(1'b1, 8'h33, 1'b0, 1'b1);
    chk_state("w3", 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("head_11", {24'h0, rddata}, 32'h11);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("head_22", {24'h0, rddata}, 32'h22);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("head_33", {24'h0, rddata}, 32'h33);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("r3", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0, 1'b1);
    chk_state("fill", 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    op(1'b1, 8'hAA, 1'b0, 1'b0);
    chk_state("ovf", 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovf_head", {24'h0, rddata}, 32'h00);
    for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("drain", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Underflow and simultaneous RD/WR while empty
    op(1'b0, 8'h00, 1'b1, 1'b0);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("unf", 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    op(1'b1, 8'h5A, 1'b1, 1'b1);
    chk("rw_empty_count", {27'h0, count}, 32'd1);
    chk("rw_empty_head", {24'h0, rddata}, 32'h5A);
    op(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous RD/WR while full
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) op(1'b1, 8'h80 + 8'(i), 1'b0, 1'b1);
    op(1'b1, 8'hC3, 1'b1, 1'b1);
    chk_state("rw_full", 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rw_full_head", {24'h0, rddata}, 32'h81);
    for (int i = 0; i < 15; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("last_c3", {24'h0, rddata}, 32'hC3);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("rw_full_drain", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 40 push/pop pairs wrapping both pointers
    op(1'b1, 8'h03, 1'b0, 1'b1);
    for (int i = 1; i < 40; i++) begin
      op(1'b1, 8'(i * 7 + 3), 1'b1, 1'b1);
      if (i == 20) chk("wrap_count", {27'h0, count}, 32'd1);
    end
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("wrap", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation with a concurrent write
    op(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) op(1'b1, 8'h40 + 8'(i), 1'b0, 1'b1);
    chk_state("pre_rst", 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset(1'b1, 8'h99);
    chk_state("mid_rst", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b1, 8'h7E, 1'b0, 1'b1);
    chk("post_rst_head", {24'h0, rddata}, 32'h7E);
    chk("post_rst_count", {27'h0, count}, 32'd1);
    op(1'b0, 8'h00, 1'b1, 1'b0);

    chk("sb_drained", sb_q.size(), 32'd0);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 Parameter NB_FIFO_DATA, default 8, SHALL set the data word width.
REQ-002 Parameter NB_FIFO_ADDR, default 4, SHALL set the address width; depth = 2**NB_FIFO_ADDR (16).
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  SHALL be the reset, synchronous and active-low (0 = reset).
REQ-005 i_fifo_WR  input  1  SHALL be the write request (push), sampled every cycle.
REQ-006 i_fifo_WRDATA  input  NB_FIFO_DATA  SHALL be the word pushed when the write is accepted.
REQ-007 i_fifo_RD  input  1  SHALL be the read request (pop), sampled every cycle; a level held N cycles pops N words.
REQ-008 o_fifo_RDDATA  output  NB_FIFO_DATA  SHALL be the head word, first-word-fall-through.
REQ-009 o_fifo_EMPTY  output  1  SHALL be high when occupancy = 0.
REQ-010 o_fifo_FULL  output  1  SHALL be high when occupancy = depth.
REQ-011 o_fifo_COUNT  output  NB_FIFO_ADDR+1  SHALL be the current occupancy, 0..depth.
REQ-012 o_fifo_OVERFLOW  output  1  SHALL be a sticky flag for a write dropped while full.
REQ-013 o_fifo_UNDERFLOW  output  1  SHALL be a sticky flag for a read ignored while empty.

Function
REQ-014 Storage SHALL be a circular array of depth words, with write pointer, read pointer and occupancy counter as registers.
REQ-015 o_fifo_RDDATA SHALL equal mem[read pointer] combinationally, so the head word is valid in any cycle with EMPTY = 0 and no read latency exists.
REQ-016 An accepted write SHALL store WRDATA at the write pointer and increment that pointer; the word SHALL be visible on RDDATA the next cycle if the FIFO was empty.
REQ-017 An accepted read SHALL increment the read pointer; the next word appears on RDDATA the following cycle.
REQ-018 Both pointers SHALL wrap modulo depth (15 -> 0) with no gap or stall.
REQ-019 Write with FULL=1 and RD=0 SHALL be dropped: no state change except OVERFLOW set to 1.
REQ-020 Read with EMPTY=1 SHALL be ignored: pointers unchanged, UNDERFLOW set to 1.
REQ-021 Simultaneous RD and WR with 0 < count < depth: both SHALL be performed and count is unchanged.
REQ-022 Simultaneous RD and WR when FULL: both SHALL be performed, count stays depth, FULL stays 1, OVERFLOW not set.
REQ-023 Simultaneous RD and WR when EMPTY: write SHALL be performed, read ignored, count -> 1, UNDERFLOW set.
REQ-024 EMPTY, FULL and COUNT SHALL be registered and updated in the same edge as the pointer change, with no combinational path from RD or WR.
REQ-025 OVERFLOW and UNDERFLOW SHALL clear only on reset.

Reset
REQ-026 With i_reset = 0 at a rising edge: pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0, OVERFLOW = 0, UNDERFLOW = 0.
REQ-027 Reset SHALL take priority over simultaneous RD or WR; a request in the reset cycle is discarded.
REQ-028 Memory contents SHALL NOT be reset; RDDATA is unspecified while EMPTY = 1.
REQ-029 Reset mid-operation SHALL discard all stored words; the first post-reset write SHALL appear at RDDATA as the head.

Structure
REQ-030 NB_FIFO_DATA and NB_FIFO_ADDR defaults SHALL live in the shared project package used by the UART and interface blocks.
REQ-031 One sub-module, fifo_regfile (synchronous write, asynchronous read array), SHALL hold the storage; pointer and flag control stays in fifo_buffer.

Verification
REQ-032 Reset, write 0x11, 0x22, 0x33 -> COUNT=3, EMPTY=0, RDDATA=0x11; three reads -> RDDATA 0x22, 0x33, then EMPTY=1, COUNT=0.
REQ-033 Write 16 words 0x00..0x0F -> FULL=1; 17th write 0xAA -> dropped, OVERFLOW=1; 16 reads return 0x00..0x0F in order.
REQ-034 Empty FIFO, RD=1 for 2 cycles -> UNDERFLOW=1, COUNT=0; RD=1 and WR=1 with 0x5A when empty -> COUNT=1, RDDATA=0x5A.
REQ-035 Full FIFO, RD=1 and WR=1 with 0xC3 -> FULL stays 1, OVERFLOW=0; after 16 further reads, the last word read is 0xC3.
REQ-036 Run 40 push/pop pairs to wrap both pointers twice -> data order preserved and no flag set.
REQ-037 Write 5 words, assert i_reset=0 for 1 cycle with WR=1 -> COUNT=0, EMPTY=1, flags 0; next write 0x7E -> RDDATA=0x7E.
